// File: rtl/victim_ctrl.sv
// Victim buffer controller: 16 tag entries in front of an external line array and L2.
// Optional hit/miss counters are enabled with `define VICTIM_STATS_EN.
module victim_ctrl #(
  parameter int WIDTH = 128,
  parameter int TAGW  = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             l1_evict,
  input  logic [TAGW-1:0]  l1_evict_tag,
  input  logic [WIDTH-1:0] l1_evict_data,
  input  logic             l1_evict_dirty,
  input  logic             l1_req,
  input  logic [TAGW-1:0]  l1_req_tag,
  output logic             l1_ready,
  output logic             l1_resp,
  output logic [WIDTH-1:0] l1_rdata,
  output logic             va_write,
  output logic [3:0]       va_index,
  output logic [WIDTH-1:0] va_datain,
  input  logic [WIDTH-1:0] va_rline,
  output logic             mem_read,
  output logic             mem_write,
  output logic [15:0]      mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_resp,
  output logic [15:0]      hit_count,
  output logic [15:0]      miss_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOOKUP = 3'd1;
  localparam logic [2:0] S_HIT    = 3'd2;
  localparam logic [2:0] S_WB     = 3'd3;
  localparam logic [2:0] S_ALLOC  = 3'd4;
  localparam logic [2:0] S_FETCH  = 3'd5;

  logic [2:0]            r_state;
  logic [15:0]           r_valid;
  logic [15:0]           r_dirty;
  logic [15:0][TAGW-1:0] r_tags;
  logic [3:0]            r_ptr;
  logic [TAGW-1:0]       r_tag;
  logic [TAGW-1:0]       r_old_tag;
  logic [WIDTH-1:0]      r_edata;
  logic                  r_edirty;
  logic [3:0]            r_va_index;
  logic [WIDTH-1:0]      r_rdata;

  logic       w_m_found, w_f_found, w_l_found;
  logic [3:0] w_m_idx, w_f_idx, w_l_idx;
  logic [3:0] w_slot;
  logic       w_use_ptr, w_need_wb, w_fetch_done;

  // Descending scans so the lowest matching index wins.
  always_comb begin
    w_m_found = 1'b0;
    w_m_idx   = 4'd0;
    w_f_found = 1'b0;
    w_f_idx   = 4'd0;
    w_l_found = 1'b0;
    w_l_idx   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (r_valid[i] && r_tags[i] == l1_evict_tag) begin
        w_m_found = 1'b1;
        w_m_idx   = 4'(i);
      end
      if (!r_valid[i]) begin
        w_f_found = 1'b1;
        w_f_idx   = 4'(i);
      end
      if (r_valid[i] && r_tags[i] == r_tag) begin
        w_l_found = 1'b1;
        w_l_idx   = 4'(i);
      end
    end
  end

  assign w_use_ptr = !w_m_found && !w_f_found;
  assign w_slot    = w_m_found ? w_m_idx : (w_f_found ? w_f_idx : r_ptr);
  assign w_need_wb = r_valid[w_slot] && r_dirty[w_slot] && (r_tags[w_slot] != l1_evict_tag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_valid    <= '0;
      r_dirty    <= '0;
      r_tags     <= '0;
      r_ptr      <= 4'd0;
      r_tag      <= '0;
      r_old_tag  <= '0;
      r_edata    <= '0;
      r_edirty   <= 1'b0;
      r_va_index <= 4'd0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Eviction has priority; a concurrent request waits for the next IDLE.
          if (l1_evict) begin
            r_tag      <= l1_evict_tag;
            r_edata    <= l1_evict_data;
            r_edirty   <= l1_evict_dirty;
            r_va_index <= w_slot;
            r_old_tag  <= r_tags[w_slot];
            if (w_use_ptr) r_ptr <= r_ptr + 4'd1;
            r_state    <= w_need_wb ? S_WB : S_ALLOC;
          end else if (l1_req) begin
            r_tag   <= l1_req_tag;
            r_state <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_l_found) begin
            r_va_index <= w_l_idx;
            r_state    <= S_HIT;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_HIT: begin
          r_valid[r_va_index] <= 1'b0;
          r_rdata             <= va_rline;
          r_state             <= S_IDLE;
        end
        S_WB: begin
          if (mem_resp) r_state <= S_ALLOC;
        end
        S_ALLOC: begin
          r_valid[r_va_index] <= 1'b1;
          r_dirty[r_va_index] <= r_edirty;
          r_tags[r_va_index]  <= r_tag;
          r_state             <= S_IDLE;
        end
        S_FETCH: begin
          if (mem_resp) begin
            r_rdata <= mem_rdata;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_fetch_done = (r_state == S_FETCH) && mem_resp;

  assign l1_ready  = (r_state == S_IDLE);
  assign l1_resp   = (r_state == S_HIT) || w_fetch_done;
  assign l1_rdata  = (r_state == S_HIT) ? va_rline :
                     (w_fetch_done ? mem_rdata : r_rdata);
  assign va_write  = (r_state == S_ALLOC);
  assign va_index  = r_va_index;
  assign va_datain = r_edata;
  assign mem_read  = (r_state == S_FETCH);
  assign mem_write = (r_state == S_WB);
  assign mem_addr  = (r_state == S_WB)    ? 16'({r_old_tag, 4'b0000}) :
                     (r_state == S_FETCH) ? 16'({r_tag, 4'b0000}) : 16'h0000;
  assign mem_wdata = mem_write ? va_rline : '0;

`ifdef VICTIM_STATS_EN
  logic [15:0] r_hit_cnt;
  logic [15:0] r_miss_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hit_cnt  <= 16'h0000;
      r_miss_cnt <= 16'h0000;
    end else begin
      if (r_state == S_HIT && r_hit_cnt != 16'hFFFF)
        r_hit_cnt <= r_hit_cnt + 16'h0001;
      if (r_state == S_LOOKUP && !w_l_found && r_miss_cnt != 16'hFFFF)
        r_miss_cnt <= r_miss_cnt + 16'h0001;
    end
  end

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;
`else
  assign hit_count  = 16'h0000;
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_victim_ctrl.sv
// Directed bench for victim_ctrl: models the line array, drives L1/L2 by hand.
module tb_victim_ctrl;
  logic         clk;
  logic         reset;
  logic         l1_evict;
  logic [11:0]  l1_evict_tag;
  logic [127:0] l1_evict_data;
  logic         l1_evict_dirty;
  logic         l1_req;
  logic [11:0]  l1_req_tag;
  logic         l1_ready;
  logic         l1_resp;
  logic [127:0] l1_rdata;
  logic         va_write;
  logic [3:0]   va_index;
  logic [127:0] va_datain;
  logic [127:0] va_rline;
  logic         mem_read;
  logic         mem_write;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_resp;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  int n_chk = 0;
  int n_err = 0;
  int n_vaw = 0;
  logic [127:0] arr [16];

  victim_ctrl #(.WIDTH(128), .TAGW(12)) dut (
    .clk(clk), .reset(reset),
    .l1_evict(l1_evict), .l1_evict_tag(l1_evict_tag), .l1_evict_data(l1_evict_data),
    .l1_evict_dirty(l1_evict_dirty), .l1_req(l1_req), .l1_req_tag(l1_req_tag),
    .l1_ready(l1_ready), .l1_resp(l1_resp), .l1_rdata(l1_rdata),
    .va_write(va_write), .va_index(va_index), .va_datain(va_datain), .va_rline(va_rline),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign va_rline = arr[va_index];
  always @(posedge clk) begin
    if (va_write) begin
      arr[va_index] <= va_datain;
      n_vaw++;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) chk("rw_excl", 128'(mem_read & mem_write), 128'd0);

  function automatic logic [127:0] rep(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic evict_nowb(input logic [11:0] t, input logic [127:0] d, input logic dty,
                            input logic [3:0] idx);
    l1_evict = 1'b1; l1_evict_tag = t; l1_evict_data = d; l1_evict_dirty = dty;
    @(negedge clk);
    l1_evict = 1'b0;
    chk("alloc_vw", 128'(va_write), 128'd1);
    chk("alloc_idx", 128'(va_index), 128'(idx));
    chk("alloc_din", va_datain, d);
    chk("alloc_rdy", 128'(l1_ready), 128'd0);
    @(negedge clk);
    chk("alloc_done", 128'(l1_ready), 128'd1);
  endtask

  task automatic req_hit(input logic [11:0] t, input logic [127:0] d, input logic [3:0] idx);
    l1_req = 1'b1; l1_req_tag = t;
    @(negedge clk);
    l1_req = 1'b0;
    chk("lookup_resp", 128'(l1_resp), 128'd0);
    @(negedge clk);
    chk("hit_resp", 128'(l1_resp), 128'd1);
    chk("hit_data", l1_rdata, d);
    chk("hit_idx", 128'(va_index), 128'(idx));
    @(negedge clk);
    chk("hit_pulse", 128'(l1_resp), 128'd0);
    chk("hit_hold", l1_rdata, d);
  endtask

  task automatic req_miss(input logic [11:0] t, input logic [127:0] d, input int lat);
    l1_req = 1'b1; l1_req_tag = t;
    @(negedge clk);
    l1_req = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chk("fetch_rd", 128'(mem_read), 128'd1);
      chk("fetch_addr", 128'(mem_addr), 128'({t, 4'h0}));
      if (k == lat) begin
        mem_resp = 1'b1; mem_rdata = d;
        #1;
        chk("fetch_resp", 128'(l1_resp), 128'd1);
        chk("fetch_data", l1_rdata, d);
      end else begin
        chk("fetch_wait", 128'(l1_resp), 128'd0);
      end
    end
    @(negedge clk);
    mem_resp = 1'b0;
    chk("fetch_done", 128'(mem_read), 128'd0);
    chk("fetch_rdy", 128'(l1_ready), 128'd1);
    chk("fetch_hold", l1_rdata, d);
  endtask

  initial begin
    int vaw0;
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vaw0;
    for (int i = 0; i < 16; i++) arr[i] = '0;
    l1_evict = 0; l1_evict_tag = 0; l1_evict_data = 0; l1_evict_dirty = 0;
    l1_req = 0; l1_req_tag = 0; mem_rdata = 0; mem_resp = 0;
    do_reset();

    // reset state
    chk("rst_rdy", 128'(l1_ready), 128'd1);
    chk("rst_resp", 128'(l1_resp), 128'd0);
    chk("rst_rdata", l1_rdata, 128'd0);
    chk("rst_vw", 128'(va_write), 128'd0);
    chk("rst_idx", 128'(va_index), 128'd0);
    chk("rst_din", va_datain, 128'd0);
    chk("rst_addr", 128'(mem_addr), 128'd0);
    chk("rst_wdata", mem_wdata, 128'd0);
    chk("rst_rdwr", 128'({mem_read, mem_write}), 128'd0);
    chk("rst_hits", 128'(hit_count), 128'd0);
    chk("rst_miss", 128'(miss_count), 128'd0);

    // clean evict, hit it back, entry is then gone
    evict_nowb(12'h0A1, rep(8'hAA), 1'b0, 4'd0);
    req_hit(12'h0A1, rep(8'hAA), 4'd0);
    vaw0 = n_vaw;
    req_miss(12'h0A1, rep(8'h33), 2);
    chk("miss_noalloc", 128'(n_vaw), 128'(vaw0));
    evict_nowb(12'h0B0, rep(8'hBB), 1'b0, 4'd0);

    // miss on empty buffer, L2 answers in the 5th FETCH cycle
    do_reset();
    vaw0 = n_vaw;
    req_miss(12'h123, rep(8'h55), 5);
    chk("miss_novaw", 128'(n_vaw), 128'(vaw0));

    // full of dirty lines: round-robin victim is written back first
    do_reset();
    for (int i = 0; i < 16; i++) evict_nowb(12'(i), rep(8'h80 + 8'(i)), 1'b1, 4'(i));
    l1_evict = 1'b1; l1_evict_tag = 12'd16; l1_evict_data = rep(8'hEE); l1_evict_dirty = 1'b1;
    @(negedge clk);
    l1_evict = 1'b0;
    chk("wb_wr", 128'(mem_write), 128'd1);
    chk("wb_rd", 128'(mem_read), 128'd0);
    chk("wb_addr", 128'(mem_addr), 128'h0000);
    chk("wb_wdata", mem_wdata, rep(8'h80));
    chk("wb_vw", 128'(va_write), 128'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("wb_held", 128'(mem_write), 128'd1);
      chk("wb_addr_held", 128'(mem_addr), 128'h0000);
    end
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("wb_alloc_vw", 128'(va_write), 128'd1);
    chk("wb_alloc_idx", 128'(va_index), 128'd0);
    chk("wb_alloc_din", va_datain, rep(8'hEE));
    chk("wb_alloc_wr", 128'(mem_write), 128'd0);
    @(negedge clk);
    l1_evict = 1'b1; l1_evict_tag = 12'd17; l1_evict_data = rep(8'hDD); l1_evict_dirty = 1'b0;
    @(negedge clk);
    l1_evict = 1'b0;
    chk("ptr_wb_addr", 128'(mem_addr), 128'h0010);
    chk("ptr_wb_wdata", mem_wdata, rep(8'h81));
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    chk("ptr_alloc_idx", 128'(va_index), 128'd1);
    chk("ptr_alloc_vw", 128'(va_write), 128'd1);
    @(negedge clk);

    // evict and req together: eviction completes first
    do_reset();
    l1_evict = 1'b1; l1_evict_tag = 12'h0B2; l1_evict_data = rep(8'hCC); l1_evict_dirty = 1'b0;
    l1_req = 1'b1; l1_req_tag = 12'h0B2;
    @(negedge clk);
    l1_evict = 1'b0;
    chk("both_alloc", 128'(va_write), 128'd1);
    chk("both_noresp", 128'(l1_resp), 128'd0);
    @(negedge clk);
    chk("both_idle", 128'(l1_ready), 128'd1);
    @(negedge clk);
    l1_req = 1'b0;
    chk("both_lookup", 128'(l1_ready), 128'd0);
    @(negedge clk);
    chk("both_hit", 128'(l1_resp), 128'd1);
    chk("both_data", l1_rdata, rep(8'hCC));
    @(negedge clk);

    // reset in the middle of FETCH
    vaw0 = n_vaw;
    l1_req = 1'b1; l1_req_tag = 12'h777;
    @(negedge clk);
    l1_req = 1'b0;
    @(negedge clk);
    chk("abort_fetch", 128'(mem_read), 128'd1);
    #2 reset = 1'b1;
    #1;
    chk("abort_rd", 128'(mem_read), 128'd0);
    chk("abort_resp", 128'(l1_resp), 128'd0);
    mem_resp = 1'b1; mem_rdata = rep(8'h99);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_rdy", 128'(l1_ready), 128'd1);
    chk("abort_rdata", l1_rdata, 128'd0);
    @(negedge clk);
    chk("abort_noresp", 128'(l1_resp), 128'd0);
    chk("abort_novaw", 128'(n_vaw), 128'(vaw0));
    mem_resp = 1'b0;

    // statistics: 2 hits, 3 misses
    do_reset();
    evict_nowb(12'hA01, rep(8'h11), 1'b0, 4'd0);
    evict_nowb(12'hA02, rep(8'h22), 1'b1, 4'd1);
    req_hit(12'hA01, rep(8'h11), 4'd0);
    req_hit(12'hA02, rep(8'h22), 4'd1);
    req_miss(12'hB01, rep(8'h44), 1);
    req_miss(12'hB02, rep(8'h45), 2);
    req_miss(12'hA01, rep(8'h46), 1);
`ifdef VICTIM_STATS_EN
    chk("stat_hits", 128'(hit_count), 128'd2);
    chk("stat_miss", 128'(miss_count), 128'd3);
`else
    chk("stat_hits", 128'(hit_count), 128'd0);
    chk("stat_miss", 128'(miss_count), 128'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/victim_ctrl.md
VICTIM_CTRL -- requirements
Module: victim_ctrl

Interface
REQ-001 Parameter WIDTH, default 128: line width in bits.
REQ-002 Parameter TAGW, default 12: tag width (address bits [15:4]).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- l1_evict  in  1  L1 presents an evicted line
- l1_evict_tag  in  TAGW  tag of the evicted line
- l1_evict_data  in  WIDTH  data of the evicted line
- l1_evict_dirty  in  1  evicted line is dirty
- l1_req  in  1  L1 miss lookup request
- l1_req_tag  in  TAGW  tag being requested
- l1_ready  out  1  controller in IDLE, accepting a new evict or request
- l1_resp  out  1  one-cycle pulse; l1_rdata is valid
- l1_rdata  out  WIDTH  returned line
- va_write  out  1  write strobe to the victim data array
- va_index  out  4  array entry index
- va_datain  out  WIDTH  array write data
- va_rline  in  WIDTH  array line at va_index (combinational)
- mem_read  out  1  L2 read request
- mem_write  out  1  L2 write request
- mem_addr  out  16  L2 address, {tag, 4'b0}
- mem_wdata  out  WIDTH  L2 write data
- mem_rdata  in  WIDTH  L2 read data
- mem_resp  in  1  L2 completes the current request
- hit_count  out  16  victim hit counter
- miss_count  out  16  victim miss counter

Function
REQ-004 The block SHALL hold 16 entries of {valid, dirty, tag} internally; all line data SHALL live in the external array.
REQ-005 The FSM states SHALL be IDLE, LOOKUP, HIT, WB, ALLOC, FETCH; l1_ready SHALL be 1 only in IDLE.
REQ-006 IDLE SHALL capture the inputs of an accepted evict or req into registers on the clock edge.
- If l1_evict and l1_req are both high in IDLE, the eviction SHALL be accepted first.
- The request SHALL be accepted in the next IDLE cycle, provided l1_req is still high.
REQ-007 Eviction victim slot selection:
- An entry with a matching valid tag SHALL be chosen first; otherwise the lowest-index invalid entry; otherwise the entry at the 4-bit round-robin pointer.
- The pointer SHALL advance by 1 modulo 16 only when it is used.
REQ-008 Eviction flow:
- If the chosen slot is valid, dirty, and its tag differs from the new tag, the FSM SHALL go to WB.
- WB SHALL hold mem_write=1, mem_addr={old tag,4'b0} and mem_wdata=va_rline until mem_resp.
- The FSM SHALL then go to ALLOC; with no writeback it SHALL go straight to ALLOC.
REQ-009 ALLOC SHALL, in one cycle, pulse va_write with va_index=slot and va_datain=evict data, set valid=1, dirty=evict_dirty, tag=evict_tag, then return to IDLE.
REQ-010 LOOKUP SHALL compare all 16 valid tags in one cycle.
- On a hit, the FSM SHALL go to HIT with va_index=hit slot.
- On a miss, the FSM SHALL go to FETCH.
REQ-011 HIT SHALL, in one cycle, assert l1_resp with l1_rdata=va_rline, clear that entry's valid bit, and return to IDLE.
- Request-to-response latency on a hit is 3 cycles (accept, LOOKUP, HIT).
REQ-012 FETCH SHALL hold mem_read=1 and mem_addr={req tag,4'b0} until mem_resp.
- In the mem_resp cycle, l1_resp=1 and l1_rdata=mem_rdata.
- The FSM SHALL then return to IDLE; the fetched line SHALL NOT be allocated.
REQ-013 mem_read and mem_write SHALL never both be high.
REQ-014 va_write SHALL be high only in ALLOC.
REQ-015 l1_rdata SHALL hold its last value between responses.

Reset
REQ-016 Reset SHALL asynchronously force:
- state=IDLE, all valid/dirty bits=0, pointer=0;
- l1_resp, va_write, mem_read, mem_write=0;
- l1_rdata, mem_addr, mem_wdata, va_index, va_datain=0;
- hit_count and miss_count=0.
REQ-017 Reset asserted mid-WB or mid-FETCH SHALL abandon the transaction; no entry update and no l1_resp SHALL follow.

Configuration
REQ-018 With VICTIM_STATS_EN defined:
- hit_count SHALL increment on each HIT, and miss_count on each LOOKUP miss.
- Both counters SHALL saturate at 16'hFFFF.
REQ-019 Without VICTIM_STATS_EN, hit_count and miss_count SHALL be constant 0 and the counter logic SHALL be absent.

Verification
REQ-020 Evict tag 12'h0A1, data 128'hAA.., clean, after reset -> va_write=1 with va_index=0 in ALLOC; then req 12'h0A1 -> l1_resp with l1_rdata=128'hAA.. 3 cycles after accept; entry 0 becomes invalid.
REQ-021 Req tag 12'h123 with an empty buffer -> mem_read=1, mem_addr=16'h1230; mem_resp after 5 cycles with mem_rdata=128'h55.. -> l1_resp in that cycle with l1_rdata=128'h55.. ; no va_write.
REQ-022 Fill 16 dirty entries with tags 0..15, then evict tag 16 -> WB with mem_addr=16'h0000 and mem_write held until mem_resp; then ALLOC at index 0; pointer becomes 1.
REQ-023 l1_evict and l1_req high in the same IDLE cycle -> ALLOC completes first; the request is accepted in the next IDLE cycle.
REQ-024 Reset pulsed during FETCH -> mem_read drops immediately, l1_resp stays 0, l1_ready=1 after release.
REQ-025 With VICTIM_STATS_EN, 2 hits and 3 misses -> hit_count=2, miss_count=3; without the macro, both stay 0.
